regfile_multiport: RTL
======================

Name: regfile_multiport

Overview:
- Parametrised multi-register file for the CPU datapath; generalises the single 4-bit load register to DEPTH registers of WIDTH bits.
- Provides one write port and two combinational read ports (A/B), optional write-to-read bypass, and an optional hardwired-zero register 0.
- Adds a per-register pending scoreboard for in-flight results.
- Adds a sequenced bulk-clear engine, so software-visible state can be zeroed without a global reset.

Parameters:
WIDTH, 4, data bits per register (>=1)
DEPTH, 4, number of registers (power of two, >=2); AW = $clog2(DEPTH) is derived, not a parameter
BYPASS, 1, 1 = accepted write data forwarded to same-cycle reads of that address; 0 = reads return stored value only
ZERO_REG0, 0, 1 = register 0 always reads 0; writes and reservations to it are ignored

Ports:
clk_cpu  in  1  CPU clock, all state on rising edge
reset_n  in  1  asynchronous, active-low reset
we  in  1  write request
waddr  in  AW  write address
wdata  in  WIDTH  write data
wr_accept  out  1  combinational: we & ~clr_busy
raddr_a  in  AW  read address A
rdata_a  out  WIDTH  read data A (combinational)
busy_a  out  1  scoreboard pending bit for raddr_a
raddr_b  in  AW  read address B
rdata_b  out  WIDTH  read data B (combinational)
busy_b  out  1  scoreboard pending bit for raddr_b
rsv_en  in  1  reserve (mark pending) register rsv_addr
rsv_addr  in  AW  reservation address
clr_req  in  1  start bulk clear
clr_busy  out  1  clear engine active
clr_done  out  1  one-cycle pulse when clear completes

Behaviour:
- Reset (reset_n low, asynchronous): all registers 0, all pending bits 0, FSM=IDLE, clear pointer 0, clr_busy=0, clr_done=0. Combinational outputs follow from that state: rdata_a=rdata_b=0, busy_a=busy_b=0, wr_accept=we.
- Write: on the rising edge with wr_accept=1, reg[waddr]<=wdata. With ZERO_REG0=1 and waddr=0, nothing is stored; wr_accept still reflects the formula.
- Read: rdata_x = reg[raddr_x]. With BYPASS=1, if wr_accept and waddr==raddr_x, then rdata_x=wdata. With ZERO_REG0=1 and raddr_x=0, rdata_x=0 regardless of bypass. Both ports may read the same address.
- Scoreboard:
  - pend[rsv_addr] is set on an edge with rsv_en=1 and clr_busy=0.
  - pend[waddr] is cleared on an accepted write.
  - Same address, same cycle, both write and reserve: set wins, so pend stays 1 (new producer).
  - Reservations to reg 0 are ignored when ZERO_REG0=1.
  - busy_x = pend[raddr_x], except with BYPASS=1 it is forced 0 when an accepted write hits raddr_x in that cycle and no same-cycle reservation targets that address.
- Clear FSM, states IDLE, CLEARING, DONE:
  - IDLE: clr_req=1 at an edge -> CLEARING, ptr<=0.
  - CLEARING: clr_busy=1. Each edge does reg[ptr]<=0, pend[ptr]<=0, ptr<=ptr+1. At ptr==DEPTH-1 -> DONE; ptr wraps to 0.
  - DONE: clr_done=1 for exactly one cycle -> IDLE.
  - Latency: clr_req sampled at edge 0; clr_busy is high for DEPTH cycles (edges 1..DEPTH); clr_done is high in the cycle after edge DEPTH. A new clr_req is accepted from IDLE at the earliest one cycle after clr_done.
  - clr_req while CLEARING or DONE is ignored, not queued.
- Boundaries:
  - During CLEARING, writes are rejected (wr_accept=0, no update, no bypass) and reservations are dropped.
  - Reads stay live and return the partially cleared contents.
  - reset_n asserted mid-clear aborts to the reset state immediately; clr_done is not pulsed.
  - Read address equal to a not-yet-cleared index returns the old value until that index's edge.

Test Plan:
- Reset then write: reset_n low->high, write reg2=0xA, reg3=0x5 -> next cycle rdata_a(raddr 2)=0xA, rdata_b(raddr 3)=0x5; all other regs read 0.
- Bypass: BYPASS=1, reg1=0x3 stored, same-cycle we=1 waddr=1 wdata=0xC with raddr_a=1 -> rdata_a=0xC combinationally. With BYPASS=0 the same stimulus gives rdata_a=0x3, then 0xC after the edge.
- Scoreboard: rsv_en addr 2 -> busy_a=1 (raddr_a=2) next cycle. Write reg2=0x7 -> busy_a=0 that cycle (BYPASS=1) and after the edge. Simultaneous rsv and write to addr 2 -> busy stays 1, reg2 updated.
- Bulk clear: DEPTH=4, regs=1,2,3,4, all pending; pulse clr_req -> clr_busy high exactly 4 cycles, a we during that window gives wr_accept=0 and no change, clr_done 1-cycle pulse, then all regs 0 and all busy 0.
- Reset mid-clear: assert reset_n low after 2 clear cycles -> clr_busy=0 immediately, no clr_done pulse, all regs 0.
- ZERO_REG0=1: write reg0=0xF and rsv_en addr 0 -> rdata(raddr 0)=0 and busy=0 always, bypass included.

Source files
------------

// File: rtl/regfile_multiport.sv
// regfile_multiport: DEPTH x WIDTH register file with one write port, two read ports,
// a pending-result scoreboard and a sequenced bulk-clear engine.
module regfile_multiport #(
    parameter int WIDTH     = 4,
    parameter int DEPTH     = 4,
    parameter int BYPASS    = 1,
    parameter int ZERO_REG0 = 0
) (
    input  logic                     clk_cpu,
    input  logic                     reset_n,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    output logic                     wr_accept,
    input  logic [$clog2(DEPTH)-1:0] raddr_a,
    output logic [WIDTH-1:0]         rdata_a,
    output logic                     busy_a,
    input  logic [$clog2(DEPTH)-1:0] raddr_b,
    output logic [WIDTH-1:0]         rdata_b,
    output logic                     busy_b,
    input  logic                     rsv_en,
    input  logic [$clog2(DEPTH)-1:0] rsv_addr,
    input  logic                     clr_req,
    output logic                     clr_busy,
    output logic                     clr_done
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, CLEARING, DONE} state_t;

    state_t           state_q, state_d;
    logic [AW-1:0]    ptr_q, ptr_d;
    logic [WIDTH-1:0] regs_q [DEPTH];
    logic [WIDTH-1:0] regs_d [DEPTH];
    logic [DEPTH-1:0] pend_q, pend_d;
    logic             wr_store, rsv_ok, hit_a, hit_b;

    always_ff @(posedge clk_cpu or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            pend_q  <= '0;
            for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            pend_q  <= pend_d;
            regs_q  <= regs_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        case (state_q)
            IDLE: begin
                state_d = clr_req ? CLEARING : IDLE;
                ptr_d   = '0;
            end
            CLEARING: begin
                state_d = (ptr_q == AW'(DEPTH - 1)) ? DONE : CLEARING;
                ptr_d   = ptr_q + 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        clr_busy = state_q == CLEARING;
        clr_done = state_q == DONE;
    end

    assign wr_accept = we & ~clr_busy;
    assign wr_store  = wr_accept & ~(ZERO_REG0 != 0 && waddr == '0);
    assign rsv_ok    = rsv_en & ~clr_busy & ~(ZERO_REG0 != 0 && rsv_addr == '0);

    // Reservation is applied after the write-clear so a same-cycle new producer keeps pend set.
    always_comb begin
        regs_d = regs_q;
        pend_d = pend_q;
        if (wr_store) regs_d[waddr] = wdata;
        if (wr_accept) pend_d[waddr] = 1'b0;
        if (rsv_ok) pend_d[rsv_addr] = 1'b1;
        if (clr_busy) begin
            regs_d[ptr_q] = '0;
            pend_d[ptr_q] = 1'b0;
        end
    end

    assign hit_a = BYPASS != 0 && wr_accept && waddr == raddr_a;
    assign hit_b = BYPASS != 0 && wr_accept && waddr == raddr_b;

    assign rdata_a = (ZERO_REG0 != 0 && raddr_a == '0) ? '0 : hit_a ? wdata : regs_q[raddr_a];
    assign rdata_b = (ZERO_REG0 != 0 && raddr_b == '0) ? '0 : hit_b ? wdata : regs_q[raddr_b];
    assign busy_a  = (hit_a && !(rsv_ok && rsv_addr == raddr_a)) ? 1'b0 : pend_q[raddr_a];
    assign busy_b  = (hit_b && !(rsv_ok && rsv_addr == raddr_b)) ? 1'b0 : pend_q[raddr_b];
endmodule
